// File: rtl/msj_duty_guard_pkg.sv
// rtl/msj_duty_guard_pkg.sv - shared types, widths and the slew helper for the duty guard.
package msj_duty_guard_pkg;

  localparam int DUTY_W      = 32;
  localparam int FAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RAMP_DOWN = 2'd1,
    FAULT     = 2'd2
  } guard_state_t;

  // Difference is taken one bit wider so extreme signed inputs cannot wrap.
  function automatic logic [DUTY_W-1:0] slew_toward(
    input logic [DUTY_W-1:0] current,
    input logic [DUTY_W-1:0] target,
    input logic [DUTY_W-1:0] step
  );
    logic signed [DUTY_W:0] diff;
    logic signed [DUTY_W:0] lim;
    diff = $signed({target[DUTY_W-1], target}) - $signed({current[DUTY_W-1], current});
    lim  = $signed({1'b0, step});
    if (diff > lim)       slew_toward = current + step;
    else if (diff < -lim) slew_toward = current - step;
    else                  slew_toward = target;
  endfunction

endpackage

// File: rtl/msj_duty_guard_channel.sv
// rtl/msj_duty_guard_channel.sv - one channel: state machine, watchdog, slew and latch strobe.
module msj_duty_guard_channel
  import msj_duty_guard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int SLEW_STEP      = 4,
  parameter int ZERO_DUTY      = 330
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DUTY_W-1:0]      duty_i,
  input  logic                   cycle_i,
  input  logic                   tick_i,
  input  logic                   emergency_off_i,
  input  logic                   clear_fault_i,
  output logic [DUTY_W-1:0]      duty_o,
  output logic                   ena_o,
  output logic                   fault_o,
  output logic                   faulted_d_o,
  output logic [FAULT_CNT_W-1:0] fault_count_o
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DUTY_W-1:0] ZERO    = DUTY_W'(ZERO_DUTY);
  localparam logic [DUTY_W-1:0] STEP    = DUTY_W'(SLEW_STEP);

  guard_state_t      state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              ena_q, ena_d;
  logic              fault_q;
  logic [DUTY_W-1:0] run_next;
  logic [DUTY_W-1:0] ramp_next;

  assign run_next  = slew_toward(duty_q, duty_i, STEP);
  assign ramp_next = slew_toward(duty_q, ZERO, STEP);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    wd_d    = wd_q;
    ena_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (cycle_i)             wd_d = '0;
        else if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
        // A strobe on the terminal-count cycle keeps the channel alive.
        if (emergency_off_i || (!cycle_i && wd_q == WD_LAST)) begin
          state_d = RAMP_DOWN;
        end else if (cycle_i) begin
          duty_d = run_next;
          ena_d  = 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (tick_i) begin
          if (duty_q == ZERO) begin
            state_d = FAULT;
          end else begin
            duty_d = ramp_next;
            ena_d  = 1'b1;
            if (ramp_next == ZERO) state_d = FAULT;
          end
        end
      end
      FAULT: begin
        duty_d = ZERO;
        if (clear_fault_i && !emergency_off_i) begin
          state_d = RUN;
          wd_d    = '0;
        end
      end
      default: begin
        state_d = FAULT;
        duty_d  = ZERO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      duty_q  <= ZERO;
      wd_q    <= '0;
      ena_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      wd_q    <= wd_d;
      ena_q   <= ena_d;
      fault_q <= (state_d != RUN);
    end
  end

  assign duty_o      = duty_q;
  assign ena_o       = ena_q;
  assign fault_o     = fault_q;
  assign faulted_d_o = (state_d != RUN);

`ifdef DUTY_GUARD_FAULT_COUNT_EN
  logic [FAULT_CNT_W-1:0] fcnt_q;
  logic                   trip;

  assign trip = (state_q == RUN) && (state_d == RAMP_DOWN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
    end else if (trip && (fcnt_q != {FAULT_CNT_W{1'b1}})) begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign fault_count_o = fcnt_q;
`else
  assign fault_count_o = '0;
`endif

endmodule

// File: rtl/msj_duty_guard.sv
// rtl/msj_duty_guard.sv - per-motor duty slew/watchdog guard; DUTY_GUARD_FAULT_COUNT_EN adds trip counters.
module msj_duty_guard
  import msj_duty_guard_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS   = 8,
  parameter int TIMEOUT_CYCLES     = 5_000_000,
  parameter int RAMP_PERIOD_CYCLES = 50_000,
  parameter int SLEW_STEP          = 4,
  parameter int ZERO_DUTY          = 330
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [NUMBER_OF_MOTORS-1:0][DUTY_W-1:0]      duty_in,
  input  logic [NUMBER_OF_MOTORS-1:0]                  cycle_in,
  input  logic                                         emergency_off,
  input  logic                                         clear_fault,
  output logic [NUMBER_OF_MOTORS-1:0][DUTY_W-1:0]      duty_out,
  output logic [NUMBER_OF_MOTORS-1:0]                  ena_out,
  output logic [NUMBER_OF_MOTORS-1:0]                  fault,
  output logic                                         fault_any,
  output logic [NUMBER_OF_MOTORS-1:0][FAULT_CNT_W-1:0] fault_count
);

  localparam int TICK_W = (RAMP_PERIOD_CYCLES > 1) ? $clog2(RAMP_PERIOD_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_PERIOD_CYCLES - 1);

  logic [TICK_W-1:0]           tick_cnt_q, tick_cnt_d;
  logic                        tick;
  logic [NUMBER_OF_MOTORS-1:0] faulted_d;
  logic                        fault_any_q;

  // One shared ramp timebase keeps all ramping channels in step.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      fault_any_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      fault_any_q <= |faulted_d;
    end
  end

  assign fault_any = fault_any_q;

  for (genvar g = 0; g < NUMBER_OF_MOTORS; g++) begin : g_ch
    msj_duty_guard_channel #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SLEW_STEP      (SLEW_STEP),
      .ZERO_DUTY      (ZERO_DUTY)
    ) u_ch (
      .clock           (clock),
      .reset           (reset),
      .duty_i          (duty_in[g]),
      .cycle_i         (cycle_in[g]),
      .tick_i          (tick),
      .emergency_off_i (emergency_off),
      .clear_fault_i   (clear_fault),
      .duty_o          (duty_out[g]),
      .ena_o           (ena_out[g]),
      .fault_o         (fault[g]),
      .faulted_d_o     (faulted_d[g]),
      .fault_count_o   (fault_count[g])
    );
  end

endmodule

// File: tb/tb_msj_duty_guard.sv
// tb/tb_msj_duty_guard.sv - directed plus randomized check of msj_duty_guard against a behavioural model.
module tb_msj_duty_guard;

  localparam int N = 8;
  localparam int T = 300;
  localparam int P = 7;
  localparam int S = 4;
  localparam int Z = 330;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [N-1:0][31:0]   duty_in;
  logic [N-1:0]         cycle_in;
  logic                 emergency_off;
  logic                 clear_fault;
  logic [N-1:0][31:0]   duty_out;
  logic [N-1:0]         ena_out;
  logic [N-1:0]         fault;
  logic                 fault_any;
  logic [N-1:0][15:0]   fault_count;

  msj_duty_guard #(
    .NUMBER_OF_MOTORS   (N),
    .TIMEOUT_CYCLES     (T),
    .RAMP_PERIOD_CYCLES (P),
    .SLEW_STEP          (S),
    .ZERO_DUTY          (Z)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .duty_in       (duty_in),
    .cycle_in      (cycle_in),
    .emergency_off (emergency_off),
    .clear_fault   (clear_fault),
    .duty_out      (duty_out),
    .ena_out       (ena_out),
    .fault         (fault),
    .fault_any     (fault_any),
    .fault_count   (fault_count)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: 0 = running, 1 = ramping to neutral, 2 = faulted.
  int     m_mode [N];
  longint m_duty [N];
  int     m_idle [N];
  bit     m_ena  [N];
  int     m_trips[N];
  bit     m_fault[N];
  bit     m_fany;
  int     m_tcnt;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic longint slew(input longint cur, input longint tgt);
    longint d;
    d = tgt - cur;
    if (d > S) return cur + S;
    if (d < -S) return cur - S;
    return tgt;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_mode[j] = 0; m_duty[j] = Z; m_idle[j] = 0;
      m_ena[j] = 0; m_trips[j] = 0; m_fault[j] = 0;
    end
    m_fany = 0;
    m_tcnt = 0;
  endtask

  task automatic model_update();
    bit tk;
    tk = (m_tcnt == P - 1);
    m_tcnt = tk ? 0 : m_tcnt + 1;
    m_fany = 0;
    for (int j = 0; j < N; j++) begin
      m_ena[j] = 0;
      if (m_mode[j] == 0) begin
        if (emergency_off) begin
          m_mode[j] = 1;
          m_trips[j] = (m_trips[j] < 65535) ? m_trips[j] + 1 : 65535;
        end else if (cycle_in[j]) begin
          m_duty[j] = slew(m_duty[j], longint'($signed(duty_in[j])));
          m_ena[j] = 1;
          m_idle[j] = 0;
        end else begin
          m_idle[j]++;
          if (m_idle[j] >= T) begin
            m_mode[j] = 1;
            m_trips[j] = (m_trips[j] < 65535) ? m_trips[j] + 1 : 65535;
          end
        end
      end else if (m_mode[j] == 1) begin
        if (tk) begin
          if (m_duty[j] == Z) m_mode[j] = 2;
          else begin
            m_duty[j] = slew(m_duty[j], Z);
            m_ena[j] = 1;
            if (m_duty[j] == Z) m_mode[j] = 2;
          end
        end
      end else begin
        if (clear_fault && !emergency_off) begin
          m_mode[j] = 0;
          m_idle[j] = 0;
        end
      end
      m_fault[j] = (m_mode[j] != 0);
      m_fany |= m_fault[j];
    end
  endtask

  task automatic compare_all();
    logic [N-1:0][31:0] e_duty;
    logic [N-1:0][15:0] e_cnt;
    logic [N-1:0]       e_ena;
    logic [N-1:0]       e_fault;
    for (int j = 0; j < N; j++) begin
      e_duty[j]  = m_duty[j][31:0];
      e_ena[j]   = m_ena[j];
      e_fault[j] = m_fault[j];
`ifdef DUTY_GUARD_FAULT_COUNT_EN
      e_cnt[j] = 16'(m_trips[j]);
`else
      e_cnt[j] = 16'd0;
`endif
    end
    chk("duty_out", 256'(duty_out), 256'(e_duty));
    chk("ena_out", 256'(ena_out), 256'(e_ena));
    chk("fault", 256'(fault), 256'(e_fault));
    chk("fault_any", 256'(fault_any), 256'(m_fany));
    chk("fault_count", 256'(fault_count), 256'(e_cnt));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_update();
    @(negedge clock);
    compare_all();
  endtask

  task automatic strobe(input logic [N-1:0] mask);
    cycle_in = mask;
    cycle();
    cycle_in = '0;
  endtask

  int up_exp[4] = '{334, 338, 340, 340};
  int ramp_vals[$];
  logic [N-1:0] keep;
  logic [N-1:0] silent;
  int n;
  int em_left;

  initial begin
    reset = 1'b1;
    cycle_in = '0;
    emergency_off = 1'b0;
    clear_fault = 1'b0;
    for (int j = 0; j < N; j++) duty_in[j] = 32'(Z);
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_duty0", 256'(duty_out[0]), 256'(330));
    chk("reset_fault_any", 256'(fault_any), 256'(0));
    compare_all();
    reset = 1'b0;

    // Slew up on ch0, down on ch1, up to 350 on ch2.
    duty_in[0] = 32'd340;
    duty_in[1] = 32'd300;
    duty_in[2] = 32'd350;
    for (int k = 0; k < 9; k++) begin
      strobe('1);
      if (k < 4) begin
        chk("slew_up_duty", 256'(duty_out[0]), 256'(up_exp[k]));
        chk("slew_up_ena", 256'(ena_out[0]), 256'(1));
      end
      cycle();
      if (k == 0) chk("ena_one_cycle", 256'(ena_out[0]), 256'(0));
      repeat (98) cycle();
    end
    chk("slew_down_land", 256'(duty_out[1]), 256'(300));
    chk("slew_up_hold", 256'(duty_out[2]), 256'(350));

    // Watchdog on ch2.
    keep = ~(N'(1) << 2);
    strobe('1);
    n = 0;
    while (!fault[2] && n < T + 20) begin
      cycle_in = (n % 100 == 50) ? keep : '0;
      cycle();
      cycle_in = '0;
      n++;
    end
    chk("watchdog_latency", 256'(n), 256'(T));
    for (int i = 0; i < 200; i++) begin
      cycle_in = (i % 100 == 50) ? keep : '0;
      cycle();
      cycle_in = '0;
      if (ena_out[2]) ramp_vals.push_back(int'(duty_out[2]));
    end
    chk("ramp_steps", 256'(ramp_vals.size()), 256'(5));
    if (ramp_vals.size() == 5) begin
      chk("ramp_first", 256'(ramp_vals[0]), 256'(346));
      chk("ramp_last", 256'(ramp_vals[4]), 256'(330));
    end
    chk("ch2_faulted", 256'(fault[2]), 256'(1));
    chk("others_run", 256'(fault & keep), 256'(0));
`ifdef DUTY_GUARD_FAULT_COUNT_EN
    chk("fault_count2", 256'(fault_count[2]), 256'(1));
`endif

    // Strobe on the exact terminal-count cycle of ch3.
    strobe('1);
    for (int i = 0; i < T - 1; i++) begin
      cycle_in = (i % 100 == 50) ? (keep & ~(N'(1) << 3)) : '0;
      cycle();
      cycle_in = '0;
    end
    strobe('1);
    repeat (5) cycle();
    chk("race_no_trip", 256'(fault[3]), 256'(0));

    // Emergency with a same-cycle clear, then recovery.
    clear_fault = 1'b1;
    cycle();
    clear_fault = 1'b0;
    strobe('1);
    emergency_off = 1'b1;
    clear_fault = 1'b1;
    cycle();
    clear_fault = 1'b0;
    chk("emerg_all_fault", 256'(fault), 256'({N{1'b1}}));
    chk("emerg_fault_any", 256'(fault_any), 256'(1));
    for (int i = 0; i < 150; i++) begin
      clear_fault = (i == 60);
      cycle();
    end
    clear_fault = 1'b0;
    chk("emerg_held", 256'(fault), 256'({N{1'b1}}));
    chk("emerg_duty_zero", 256'(duty_out), 256'({N{32'd330}}));
    emergency_off = 1'b0;
    clear_fault = 1'b1;
    cycle();
    clear_fault = 1'b0;
    chk("recover_fault_any", 256'(fault_any), 256'(0));
    strobe('1);
    chk("recover_slew", 256'(duty_out[0]), 256'(334));

    // Reset in the middle of a ramp.
    duty_in[0] = 32'd360;
    repeat (3) strobe('1);
    emergency_off = 1'b1;
    cycle();
    emergency_off = 1'b0;
    repeat (2) cycle();
    chk("midramp_fault", 256'(fault[0]), 256'(1));
    reset = 1'b1;
    #1;
    chk("rst_duty", 256'(duty_out), 256'({N{32'd330}}));
    chk("rst_fault", 256'(fault), 256'(0));
    chk("rst_ena", 256'(ena_out), 256'(0));
    chk("rst_fault_any", 256'(fault_any), 256'(0));
    chk("rst_fault_count", 256'(fault_count), 256'(0));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Randomized traffic.
    silent = '0;
    em_left = 0;
    for (int c = 0; c < 20000; c++) begin
      if (c % 1000 == 0) silent = N'($urandom_range(0, 255) & $urandom_range(0, 255));
      for (int j = 0; j < N; j++) begin
        cycle_in[j] = !silent[j] && ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 49) == 0)
          duty_in[j] = ($urandom_range(0, 49) == 0) ? $urandom() : 32'(250 + $urandom_range(0, 160));
      end
      if (em_left > 0) begin
        em_left--;
        emergency_off = 1'b1;
      end else begin
        emergency_off = 1'b0;
        if ($urandom_range(0, 2999) == 0) em_left = $urandom_range(20, 200);
      end
      clear_fault = ($urandom_range(0, 149) == 0);
      cycle();
    end
    cycle_in = '0;
    clear_fault = 1'b0;
    emergency_off = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
